// File: rtl/ram_bus_arbiter_if.sv
// CPU-side bus of the SRAM arbiter: one fetch (read-only) port and one data port.
// Handshake: a requester raises req with stable payload; the arbiter answers with a one-cycle ack (err alongside for unmapped).
interface ram_bus_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        err;

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  if_rdata, if_ack, mem_rdata, mem_ack, err
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output if_rdata, if_ack, mem_rdata, mem_ack, err
   );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-port arbiter onto two asynchronous SRAM banks (BaseRAM / ExtRAM).
// Data port wins over fetch port; each access runs a fixed strobe sequence, then acks in DONE.
module ram_bus_arbiter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   ram_bus_arbiter_if.slave bus,
   inout  wire  [31:0]      base_ram_data,
   output logic [19:0]      base_ram_addr,
   output logic [3:0]       base_ram_be_n,
   output logic             base_ram_ce_n,
   output logic             base_ram_oe_n,
   output logic             base_ram_we_n,
   inout  wire  [31:0]      ext_ram_data,
   output logic [19:0]      ext_ram_addr,
   output logic [3:0]       ext_ram_be_n,
   output logic             ext_ram_ce_n,
   output logic             ext_ram_oe_n,
   output logic             ext_ram_we_n,
   output logic [2:0]       dbg_state
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] READ     = 3'd1;
   localparam logic [2:0] WR_SETUP = 3'd2;
   localparam logic [2:0] WR_PULSE = 3'd3;
   localparam logic [2:0] WR_HOLD  = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;

   localparam int CW = $clog2(WAIT_CYCLES + 1) + 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic          id_mem;
   logic          ext_sel;
   logic          unmapped;
   logic [3:0]    be_q;
   logic [19:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   if_rdata_q;
   logic [31:0]   mem_rdata_q;

   logic          g_mem;
   logic [31:0]   g_addr;
   logic          g_we;
   logic [3:0]    g_be;
   logic          g_mapped;
   logic [31:0]   rd_data;
   logic          unused_addr_bits;

   // Candidate grant: the data port always wins when both are pending.
   always_comb begin
      g_mem    = bus.mem_req;
      g_addr   = g_mem ? bus.mem_addr : bus.if_addr;
      g_we     = g_mem & bus.mem_we;
      g_be     = g_mem ? bus.mem_be : 4'hF;
      g_mapped = (g_addr[31:23] == 9'h100);
      rd_data  = ext_sel ? ext_ram_data : base_ram_data;
   end

   assign unused_addr_bits = ^g_addr[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         id_mem      <= 1'b0;
         ext_sel     <= 1'b0;
         unmapped    <= 1'b0;
         be_q        <= 4'h0;
         addr_q      <= 20'h0;
         wdata_q     <= 32'h0;
         if_rdata_q  <= 32'h0;
         mem_rdata_q <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.mem_req || bus.if_req) begin
                  id_mem   <= g_mem;
                  ext_sel  <= g_addr[22];
                  unmapped <= !g_mapped;
                  be_q     <= g_be;
                  addr_q   <= g_addr[21:2];
                  wdata_q  <= bus.mem_wdata;
                  cnt      <= '0;
                  if (!g_mapped) begin
                     state <= DONE;
                     if (!g_we) begin
                        if (g_mem) mem_rdata_q <= 32'h0;
                        else       if_rdata_q  <= 32'h0;
                     end
                  end else if (g_we && (g_be == 4'h0)) begin
                     state <= DONE;
                  end else if (g_we) begin
                     state <= WR_SETUP;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (cnt == LAST) begin
                  if (id_mem) mem_rdata_q <= rd_data;
                  else        if_rdata_q  <= rd_data;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WR_SETUP: begin
               cnt   <= '0;
               state <= WR_PULSE;
            end
            WR_PULSE: begin
               if (cnt == LAST) state <= WR_HOLD;
               else             cnt   <= cnt + 1'b1;
            end
            WR_HOLD: state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic       in_access;
   logic       in_write;
   logic       use_base;
   logic       use_ext;
   logic [3:0] strobe_be_n;

   // Strobes decode straight from registered state so reset drops them asynchronously.
   always_comb begin
      in_access   = (state == READ) || (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
      in_write    = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
      use_base    = in_access && !ext_sel;
      use_ext     = in_access && ext_sel;
      strobe_be_n = (state == READ) ? 4'h0 : ~be_q;
   end

   assign base_ram_addr = addr_q;
   assign base_ram_ce_n = !use_base;
   assign base_ram_oe_n = !(use_base && (state == READ));
   assign base_ram_we_n = !(use_base && (state == WR_PULSE));
   assign base_ram_be_n = use_base ? strobe_be_n : 4'hF;
   assign base_ram_data = (use_base && in_write) ? wdata_q : 32'bz;

   assign ext_ram_addr  = addr_q;
   assign ext_ram_ce_n  = !use_ext;
   assign ext_ram_oe_n  = !(use_ext && (state == READ));
   assign ext_ram_we_n  = !(use_ext && (state == WR_PULSE));
   assign ext_ram_be_n  = use_ext ? strobe_be_n : 4'hF;
   assign ext_ram_data  = (use_ext && in_write) ? wdata_q : 32'bz;

   assign bus.if_ack    = (state == DONE) && !id_mem;
   assign bus.mem_ack   = (state == DONE) && id_mem;
   assign bus.err       = (state == DONE) && unmapped;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign dbg_state     = state;

endmodule

// File: doc/ram_bus_arbiter.md
RAM_BUS_ARBITER -- requirements
Module: ram_bus_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, meaning extra cycles each SRAM OE/WE strobe is held (strobe length = WAIT_CYCLES+1).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch-port read request, held until if_ack.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_rdata  output  32  fetch read data.
REQ-007 if_ack  output  1  one-cycle completion pulse for the fetch port.
REQ-008 mem_req  input  1  data-port request, held until mem_ack.
REQ-009 mem_we  input  1  data-port write (1) / read (0).
REQ-010 mem_be  input  4  data-port byte enables, active-high.
REQ-011 mem_addr / mem_wdata  input  32 / 32  data-port address / write data.
REQ-012 mem_rdata  output  32  data-port read data.
REQ-013 mem_ack  output  1  one-cycle completion pulse for the data port.
REQ-014 err  output  1  one-cycle pulse with an ack for an unmapped address.
REQ-015 base_ram_data  inout 32; base_ram_addr out 20; base_ram_be_n out 4; base_ram_ce_n, base_ram_oe_n, base_ram_we_n out 1 each; active-low strobes.
REQ-016 ext_ram_* ports identical to REQ-015 for the ExtRAM bank.

Function
REQ-017 Address map: 0x80000000-0x803FFFFF selects BaseRAM, 0x80400000-0x807FFFFF selects ExtRAM, all others unmapped; SRAM address = addr[21:2].
REQ-018 Arbitration only in IDLE: mem_req has fixed priority over if_req; the loser waits with its request held.
REQ-019 At grant, addr, we, be, wdata and the requester ID are latched; input changes after grant are ignored until ack.
REQ-020 States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-021 Transitions: IDLE->READ (mapped read), IDLE->WR_SETUP (mapped write, be!=0), IDLE->DONE (unmapped, or write with be==0), READ->DONE after WAIT_CYCLES+1 cycles, WR_SETUP->WR_PULSE after 1 cycle, WR_PULSE->WR_HOLD after WAIT_CYCLES+1 cycles, WR_HOLD->DONE after 1 cycle, DONE->IDLE unconditionally.
REQ-022 READ: selected bank ce_n=0, oe_n=0, we_n=1, be_n=4'b0000; data captured on the last READ edge.
REQ-023 Writes: selected bank ce_n=0 in WR_SETUP/WR_PULSE/WR_HOLD, we_n=0 only in WR_PULSE, oe_n=1, be_n=~be.
REQ-024 The data bus is driven with the latched wdata only in WR_SETUP, WR_PULSE and WR_HOLD for the selected bank; otherwise both buses are high-Z.
REQ-025 The unselected bank keeps ce_n/oe_n/we_n=1 and be_n=4'hF throughout.
REQ-026 In DONE, exactly the granted port's ack is 1; rdata of that port updates for reads and holds until its next read completes.
REQ-027 Unmapped accesses produce no SRAM strobes, return rdata=0 for reads, and assert err together with the ack.
REQ-028 Latency with WAIT_CYCLES=1 (grant in cycle 0): read ack in cycle 3; write ack in cycle 5; unmapped or be==0 ack in cycle 1.
REQ-029 After an ack, the earliest next grant is the cycle after DONE; a requester that still holds req in that cycle starts a new access.
REQ-030 Writes of partial bytes leave unenabled SRAM bytes unchanged; byte lane n maps to data[8n+7:8n].

Reset
REQ-031 While rst_n=0: state=IDLE, all ce_n/oe_n/we_n=1, be_n=4'hF, addresses=0, data buses high-Z, if_ack=mem_ack=err=0, if_rdata=mem_rdata=0.
REQ-032 Assertion of rst_n mid-access forces the REQ-031 values immediately; the aborted access is never acked.
REQ-033 The first grant occurs no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-034 Scenario: WAIT_CYCLES=1, SRAM model holds 0x12345678 at base word 0, if_req with addr 0x80000000 -> oe_n low in cycles 1-2, if_ack=1 and if_rdata=0x12345678 in cycle 3.
REQ-035 Scenario: mem write to 0x80400004, be=4'b0011, wdata=0xAABBCCDD, old word 0x11223344 -> ext we_n low in cycles 2-3, mem_ack in cycle 5; a readback returns 0x1122CCDD.
REQ-036 Scenario: if_req and mem_req asserted in the same cycle -> mem served first; if_ack follows mem_ack, with the fetch grant in the cycle after DONE.
REQ-037 Scenario: mem read of 0x00001000 -> mem_ack=1, err=1, mem_rdata=0 in cycle 1; no strobe on either bank.
REQ-038 Scenario: rst_n pulsed low during WR_PULSE -> we_n/ce_n return to 1 asynchronously, bus is high-Z, no ack; the next request completes normally.
REQ-039 Scenario: WAIT_CYCLES=3 read -> oe_n low for exactly 4 cycles, ack in cycle 5.
